fetch_prefetch: RTL and testbench
=================================

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall_d  input  1  decode not accepting; holds decode outputs.
REQ-007 SHALL have port pcsrc_e  input  1  redirect request from execute.
REQ-008 SHALL have port pc_target_e  input  XLEN  redirect target.
REQ-009 SHALL have port imem_req  output  1  fetch request.
REQ-010 SHALL have port imem_addr  output  XLEN  fetch address.
REQ-011 SHALL have port imem_ready  input  1  memory accepts; imem_rdata valid in the same cycle.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-013 SHALL have ports instr_d, pc_d, pcplus4_d  output  32/XLEN/XLEN  decode-stage register contents.
REQ-014 SHALL have port valid_d  output  1  decode register holds a real instruction.
REQ-015 SHALL have port q_count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-016 SHALL hold fetch PC pc_f; imem_addr = pc_f.
REQ-017 SHALL drive imem_req = ~full & ~pcsrc_e, where full = (q_count == DEPTH).
REQ-018 SHALL push {imem_rdata, pc_f, pc_f+4} and advance pc_f <= pc_f+4 (mod 2^XLEN) on each edge where imem_req & imem_ready.
REQ-019 SHALL hold pc_f and push nothing when imem_ready=0 or full.
REQ-020 SHALL load the decode register when (~valid_d | ~stall_d): from queue head if non-empty (pop, valid_d<=1), else bypass a same-cycle push (valid_d<=1), else instr_d/pc_d/pcplus4_d <= 0, valid_d <= 0.
REQ-021 SHALL keep the decode register and valid_d unchanged while stall_d=1 & valid_d=1.
REQ-022 SHALL deliver a fetch accepted with the queue empty and the decode register loadable to instr_d on the next edge (1-cycle latency).
REQ-023 SHALL keep q_count unchanged on a simultaneous push and pop; the bypass path SHALL not change q_count.
REQ-024 SHALL present entries to decode in strict fetch order.
REQ-025 SHALL, on an edge with pcsrc_e=1, set pc_f <= {pc_target_e[XLEN-1:2],2'b00}, empty the queue (q_count<=0), set valid_d<=0 and zero decode outputs, regardless of stall_d, full or imem_ready.
REQ-026 SHALL give redirect priority over push, pop and stall; no pre-redirect instruction SHALL appear on instr_d after that edge.
REQ-027 SHALL wrap queue read/write pointers modulo DEPTH.
REQ-028 SHALL issue the first post-redirect request in the cycle after the redirect edge.

Reset
REQ-029 SHALL, while rst=0, force pc_f=RESET_PC, q_count=0, valid_d=0, instr_d=pc_d=pcplus4_d=0, pointers=0.
REQ-030 SHALL, in the first cycle after reset release, assert imem_req with imem_addr=RESET_PC.
REQ-031 SHALL, on rst asserted mid-operation, discard queued entries and decode contents immediately.

Verification
REQ-032 SHALL cover: reset release, imem_ready=1, stall_d=0, rdata=0xA0+n -> instr_d 0xA0,0xA1,... on consecutive cycles, pc_d 0,4,8, pcplus4_d 4,8,12, q_count=0.
REQ-033 SHALL cover: stall_d=1 for 8 cycles, imem_ready=1 -> q_count rises to 4, imem_req=0, pc_f held at 0x14, decode holds pc_d=0; stall release drains pc_d 4,8,0xC,0x10 in order.
REQ-034 SHALL cover: queue full, stall_d=1, pcsrc_e=1 pc_target_e=0x203 -> next edge q_count=0, valid_d=0, imem_addr=0x200; next cycle instr_d from 0x200.
REQ-035 SHALL cover: imem_ready toggling 1/0 each cycle, stall_d=0 -> valid_d alternates 1/0, no PC skipped or duplicated.
REQ-036 SHALL cover: pc_f=0xFFFF_FFFC accepted -> pcplus4_d=0, next imem_addr=0.
REQ-037 SHALL cover: rst low with q_count=3 -> all outputs 0, q_count=0 without a clock edge.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage with a small prefetch queue feeding the decode register.
// Fetches run ahead of decode while it stalls; a redirect from execute flushes everything.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_d,
    input  logic                      pcsrc_e,
    input  logic [XLEN-1:0]           pc_target_e,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic                      imem_ready,
    input  logic [31:0]               imem_rdata,
    output logic [31:0]               instr_d,
    output logic [XLEN-1:0]           pc_d,
    output logic [XLEN-1:0]           pcplus4_d,
    output logic                      valid_d,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] pcPlus4F;
    logic [31:0]     qInstr [DEPTH];
    logic [XLEN-1:0] qPc    [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            fetchFire;
    logic            loadDecode;
    logic            popQ;
    logic            bypass;
    logic            pushQ;
    logic [XLEN-1:0] headPc;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign imem_req   = ~full & ~pcsrc_e;
    assign imem_addr  = pcF;
    assign pcPlus4F   = pcF + XLEN'(4);
    assign fetchFire  = imem_req & imem_ready;
    assign loadDecode = ~valid_d | ~stall_d;
    assign popQ       = loadDecode & ~empty;
    // An empty queue lets a fresh fetch go straight into decode without occupying a slot.
    assign bypass     = loadDecode & empty & fetchFire;
    assign pushQ      = fetchFire & ~bypass;
    assign headPc     = qPc[rdPtr];
    assign q_count    = count;

    always_ff @(posedge clk) begin
        if (pushQ) begin
            qInstr[wrPtr] <= imem_rdata;
            qPc[wrPtr]    <= pcF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcF       <= RESET_PC;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            instr_d   <= '0;
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (pcsrc_e) begin
            // Redirect wins over everything; anything fetched from the old path is dropped.
            pcF       <= pc_target_e & ~XLEN'(3);
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            instr_d   <= '0;
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else begin
            if (fetchFire) begin
                pcF <= pcPlus4F;
            end
            if (pushQ) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (popQ) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (pushQ && !popQ) begin
                count <= count + CW'(1);
            end else if (popQ && !pushQ) begin
                count <= count - CW'(1);
            end
            if (loadDecode) begin
                if (!empty) begin
                    instr_d   <= qInstr[rdPtr];
                    pc_d      <= headPc;
                    pcplus4_d <= headPc + XLEN'(4);
                    valid_d   <= 1'b1;
                end else if (fetchFire) begin
                    instr_d   <= imem_rdata;
                    pc_d      <= pcF;
                    pcplus4_d <= pcPlus4F;
                    valid_d   <= 1'b1;
                end else begin
                    instr_d   <= '0;
                    pc_d      <= '0;
                    pcplus4_d <= '0;
                    valid_d   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed vector table, corner-case sequences
// and a randomized run compared against a queue-based reference model.
module tb_fetch_prefetch;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_d;
    logic        pcsrc_e;
    logic [31:0] pc_target_e;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_d    (stall_d),
        .pcsrc_e    (pcsrc_e),
        .pc_target_e(pc_target_e),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .q_count    (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: every word address holds a distinct instruction.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    assign imem_rdata = memWord(imem_addr);

    // Reference model: fetched words waiting for decode, in fetch order.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mPcD;
    logic [31:0] mP4;

    function automatic logic modelReq();
        return (mq.size() < DEPTH) && !pcsrc_e;
    endfunction

    task automatic modelReset();
        mq.delete();
        mPc    = RESET_PC;
        mValid = 1'b0;
        mInstr = '0;
        mPcD   = '0;
        mP4    = '0;
    endtask

    task automatic modelStep();
        entry_t e;
        logic   fire;
        if (pcsrc_e) begin
            mq.delete();
            mPc    = pc_target_e & ~32'h3;
            mValid = 1'b0;
            mInstr = '0;
            mPcD   = '0;
            mP4    = '0;
        end else begin
            fire = modelReq() && imem_ready;
            if (fire) begin
                e.instr = memWord(mPc);
                e.pc    = mPc;
                mq.push_back(e);
                mPc = mPc + 32'd4;
            end
            if (!mValid || !stall_d) begin
                if (mq.size() > 0) begin
                    e      = mq.pop_front();
                    mValid = 1'b1;
                    mInstr = e.instr;
                    mPcD   = e.pc;
                    mP4    = e.pc + 32'd4;
                end else begin
                    mValid = 1'b0;
                    mInstr = '0;
                    mPcD   = '0;
                    mP4    = '0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eReq, input logic [31:0] eAddr,
                               input logic eValid, input logic [31:0] eInstr,
                               input logic [31:0] ePcD, input logic [31:0] eP4,
                               input logic [2:0] eCount);
        check({tag, ".req"},     32'(imem_req),  32'(eReq));
        check({tag, ".addr"},    imem_addr,      eAddr);
        check({tag, ".valid"},   32'(valid_d),   32'(eValid));
        check({tag, ".instr"},   instr_d,        eInstr);
        check({tag, ".pcD"},     pc_d,           ePcD);
        check({tag, ".pcPlus4"}, pcplus4_d,      eP4);
        check({tag, ".qCount"},  32'(q_count),   32'(eCount));
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic p, input logic [31:0] t);
        stall_d     = s;
        imem_ready  = r;
        pcsrc_e     = p;
        pc_target_e = t;
    endtask

    // One clock: DUT and model both advance on the rising edge, outputs settle by the falling edge.
    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstRelease", 1'b1, RESET_PC, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    endtask

    typedef struct {
        bit          rstBefore;
        bit          stall;
        bit          ready;
        logic [31:0] eAddr;
        bit          eReq;
        bit          eValid;
        logic [31:0] eInstr;
        logic [31:0] ePcD;
        logic [31:0] eP4;
        logic [2:0]  eCount;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] expPc;
        logic        s;
        logic        r;
        logic        p;
        logic [31:0] t;

        // Streaming after reset, then stall-fill-drain after a second reset.
        vecs[0]  = '{1, 0, 1, 32'h04, 1, 1, 32'hA0, 32'h00, 32'h04, 3'd0};
        vecs[1]  = '{0, 0, 1, 32'h08, 1, 1, 32'hA1, 32'h04, 32'h08, 3'd0};
        vecs[2]  = '{0, 0, 1, 32'h0C, 1, 1, 32'hA2, 32'h08, 32'h0C, 3'd0};
        vecs[3]  = '{1, 1, 1, 32'h04, 1, 1, 32'hA0, 32'h00, 32'h04, 3'd0};
        vecs[4]  = '{0, 1, 1, 32'h08, 1, 1, 32'hA0, 32'h00, 32'h04, 3'd1};
        vecs[5]  = '{0, 1, 1, 32'h0C, 1, 1, 32'hA0, 32'h00, 32'h04, 3'd2};
        vecs[6]  = '{0, 1, 1, 32'h10, 1, 1, 32'hA0, 32'h00, 32'h04, 3'd3};
        vecs[7]  = '{0, 1, 1, 32'h14, 0, 1, 32'hA0, 32'h00, 32'h04, 3'd4};
        vecs[8]  = '{0, 1, 1, 32'h14, 0, 1, 32'hA0, 32'h00, 32'h04, 3'd4};
        vecs[9]  = '{0, 1, 1, 32'h14, 0, 1, 32'hA0, 32'h00, 32'h04, 3'd4};
        vecs[10] = '{0, 1, 1, 32'h14, 0, 1, 32'hA0, 32'h00, 32'h04, 3'd4};
        vecs[11] = '{0, 0, 1, 32'h14, 1, 1, 32'hA1, 32'h04, 32'h08, 3'd3};
        vecs[12] = '{0, 0, 0, 32'h14, 1, 1, 32'hA2, 32'h08, 32'h0C, 3'd2};
        vecs[13] = '{0, 0, 0, 32'h14, 1, 1, 32'hA3, 32'h0C, 32'h10, 3'd1};
        vecs[14] = '{0, 0, 0, 32'h14, 1, 1, 32'hA4, 32'h10, 32'h14, 3'd0};
        vecs[15] = '{0, 0, 0, 32'h14, 1, 0, 32'h00, 32'h00, 32'h00, 3'd0};

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        modelReset();
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rstBefore) doReset();
            applyStimulus(vecs[i].stall, vecs[i].ready, 1'b0, 32'h0);
            cycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid,
                        vecs[i].eInstr, vecs[i].ePcD, vecs[i].eP4, vecs[i].eCount);
        end

        // Redirect while the queue is full and decode is stalled.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) cycle();
        checkOutput("fullBefore", 1'b0, 32'h14, 1'b1, 32'hA0, 32'h0, 32'h4, 3'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h203);
        #1;
        check("redirReq", 32'(imem_req), 32'h0);
        cycle();
        checkOutput("redirect", 1'b0, 32'h200, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        check("postRedirReq", 32'(imem_req), 32'h1);
        cycle();
        checkOutput("postRedirect", 1'b1, 32'h204, 1'b1, memWord(32'h200), 32'h200, 32'h204, 3'd0);

        // Fetch address wraps past the top of the address space.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        cycle();
        checkOutput("wrapRedirect", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        cycle();
        checkOutput("wrap", 1'b1, 32'h0, 1'b1, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 3'd0);

        // Memory ready on alternate cycles: decode valid alternates, PCs stay contiguous.
        doReset();
        expPc = RESET_PC;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i % 2) == 0, 1'b0, 32'h0);
            cycle();
            if ((i % 2) == 0) begin
                checkOutput($sformatf("toggle%0d", i), 1'b1, expPc + 32'd4, 1'b1, memWord(expPc),
                            expPc, expPc + 32'd4, 3'd0);
                expPc = expPc + 32'd4;
            end else begin
                checkOutput($sformatf("toggle%0d", i), 1'b1, expPc, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
            end
        end

        // Asynchronous reset with three entries queued, observed before any clock edge.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) cycle();
        checkOutput("preRst", 1'b1, 32'h10, 1'b1, 32'hA0, 32'h0, 32'h4, 3'd3);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
        #1;
        checkOutput("asyncRst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);

        // Randomized traffic against the reference model.
        doReset();
        for (int n = 0; n < 2000; n++) begin
            s = $urandom_range(0, 9) < 4;
            r = $urandom_range(0, 9) < 6;
            p = $urandom_range(0, 19) == 0;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
            applyStimulus(s, r, p, t);
            #1;
            checkOutput("rnd", modelReq(), mPc, mValid, mInstr, mPcD, mP4, 3'(mq.size()));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
